// File: rtl/uart_rx_fifo_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_pkg
//   Shared definitions for the UART link: receiver FSM state encoding,
//   8N1 framing constants and default geometry. The transmitter side can
//   import the same package so both ends agree on line levels and divisor.
//   No ports (package only).
// ---------------------------------------------------------------------------
package uart_rx_fifo_pkg;

    // Default link geometry: 16 clocks per bit, 8 data bits, 4-entry buffer
    localparam int BAUD_DIV_DEF   = 16;
    localparam int DATA_BITS_DEF  = 8;
    localparam int FIFO_DEPTH_DEF = 4;

    // 8N1 line levels: idle and stop are mark (1), start is space (0)
    localparam logic IDLE_LEVEL = 1'b1;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;

    // Receiver sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // Width needed to index 0..n-1, never less than one bit
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_if
//   Consumer-side bundle of the UART receiver: the pop handshake, the head
//   byte and the status/error strobes.
//   master : receiver side  (drives dout, rd_rdy, frame_err, overrun, busy)
//   slave  : consumer side  (drives rd_en)
//   Signals:
//     rd_en      pop request from consumer
//     dout       FIFO head byte, meaningful while rd_rdy=1
//     rd_rdy     FIFO non-empty
//     frame_err  one-cycle pulse, bad stop bit, byte dropped
//     overrun    one-cycle pulse, byte arrived with FIFO full, byte dropped
//     busy       receiver is inside a character
// ---------------------------------------------------------------------------
interface uart_rx_fifo_if #(
    parameter int DATA_BITS = 8
) ();

    logic                 rd_en;
    logic [DATA_BITS-1:0] dout;
    logic                 rd_rdy;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        input  rd_en,
        output dout,
        output rd_rdy,
        output frame_err,
        output overrun,
        output busy
    );

    modport slave (
        output rd_en,
        input  dout,
        input  rd_rdy,
        input  frame_err,
        input  overrun,
        input  busy
    );

endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//   Single-clock first-word-fall-through FIFO. The head entry is always
//   presented on dout_o; a pop simply advances the read pointer. Usable on
//   either side of the UART.
//   Ports:
//     clk      in   system clock, rising edge
//     rst_n    in   synchronous reset, active-low (pointers only)
//     push_i   in   write din_i this edge (accepted if not full, or if a pop
//                   frees a slot in the same edge)
//     pop_i    in   drop head entry this edge (ignored while empty)
//     din_i    in   write data
//     dout_o   out  head entry, forced to 0 while empty
//     empty_o  out  no entries
//     full_o   out  DEPTH entries
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wrPtr_q;
    logic [AW:0]      rdPtr_q;
    logic             doPush;
    logic             doPop;

    // Pointers carry one extra wrap bit so that full and empty are both
    // distinguishable without a separate occupancy counter. A push into a
    // full FIFO is still legal when a pop frees the head slot in the same
    // edge; a pop of an empty FIFO is simply ignored.
    always_comb begin
        empty_o = (wrPtr_q == rdPtr_q);
        full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                  (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
        doPop   = pop_i && !empty_o;
        doPush  = push_i && (!full_o || doPop);
        dout_o  = empty_o ? '0 : mem_q[rdPtr_q[AW-1:0]];
    end

    // Pointer update; reset empties the buffer without touching storage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + PTR_ONE;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PTR_ONE;
            end
        end
    end

    // Storage array has no reset; stale contents are never exposed because
    // dout_o is masked while empty
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q[AW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//   UART 8N1 receiver with a small receive buffer. The asynchronous serial
//   line is synchronised, start bits are detected on a falling edge and
//   verified at mid-bit, data bits are sampled mid-bit LSB first, and the
//   stop bit decides whether the byte is buffered, dropped as an overrun,
//   or dropped as a framing error.
//   Ports:
//     clk    in   system clock, rising edge
//     rst_n  in   synchronous reset, active-low
//     rx_i   in   asynchronous serial input, idle high
//     bus    master modport of uart_rx_fifo_if:
//              rd_en (in), dout, rd_rdy, frame_err, overrun, busy (out)
// ---------------------------------------------------------------------------
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int BAUD_DIV   = BAUD_DIV_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rx_i,
    uart_rx_fifo_if.master  bus
);

    localparam int CNT_W = idxWidth(BAUD_DIV);
    localparam int IDX_W = idxWidth(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BAUD_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    // Synchroniser and edge detect
    logic                 sync1_q;
    logic                 rxs_q;
    logic                 rxsDly_q;
    logic                 rxsFall;

    // Sequencer state
    uart_state_e          state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [IDX_W-1:0]     idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 frameErr_q;
    logic                 overrun_q;
    logic                 busy_q;

    // Buffer interface
    logic                 stopSample;
    logic                 stopGood;
    logic                 popReq;
    logic                 pushReq;
    logic                 overrunNow;
    logic                 frameErrNow;
    logic [DATA_BITS-1:0] fifoDout;
    logic                 fifoEmpty;
    logic                 fifoFull;

    // Two-flop synchroniser on the raw line plus one extra delay stage for
    // edge detection. All three flops come out of reset at the idle level
    // so that reset itself never looks like a start-bit edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q  <= IDLE_LEVEL;
            rxs_q    <= IDLE_LEVEL;
            rxsDly_q <= IDLE_LEVEL;
        end else begin
            sync1_q  <= rx_i;
            rxs_q    <= sync1_q;
            rxsDly_q <= rxs_q;
        end
    end

    // Decisions taken at the stop-bit sample point. The push has to be
    // combinational so the byte lands in the buffer on the sample edge
    // itself; a pop in that same edge frees room, which is why a full
    // buffer being drained does not count as an overrun.
    always_comb begin
        rxsFall     = rxsDly_q && !rxs_q;
        stopSample  = (state_q == STOP) && (cnt_q == LAST_CNT);
        stopGood    = (rxs_q == STOP_BIT);
        popReq      = bus.rd_en && !fifoEmpty;
        pushReq     = stopSample && stopGood && (!fifoFull || popReq);
        overrunNow  = stopSample && stopGood && fifoFull && !popReq;
        frameErrNow = stopSample && !stopGood;
    end

    // Receive sequencer. START checks the line half a bit after the edge,
    // which then places every later sample at mid-bit. STOP returns to IDLE
    // at mid stop bit, so the receiver is re-armed half a bit early and a
    // start bit that follows immediately is still caught. Because IDLE only
    // leaves on a falling edge, a held-low break raises one framing error
    // and then waits for the line to go high and low again. Error strobes
    // default low every cycle so each one is a single-cycle pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            frameErr_q <= 1'b0;
            overrun_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            frameErr_q <= 1'b0;
            overrun_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rxsFall) begin
                        state_q <= START;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_q == HALF_CNT) begin
                        cnt_q <= '0;
                        if (rxs_q == START_BIT) begin
                            state_q <= DATA;
                            idx_q   <= '0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                DATA: begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_q   <= '0;
                        shift_q <= {rxs_q, shift_q[DATA_BITS-1:1]};
                        if (idx_q == LAST_IDX) begin
                            state_q <= STOP;
                        end else begin
                            idx_q <= idx_q + IDX_ONE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                STOP: begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_q      <= '0;
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        frameErr_q <= frameErrNow;
                        overrun_q  <= overrunNow;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (pushReq),
        .pop_i   (popReq),
        .din_i   (shift_q),
        .dout_o  (fifoDout),
        .empty_o (fifoEmpty),
        .full_o  (fifoFull)
    );

    // Consumer-facing outputs
    assign bus.dout      = fifoDout;
    assign bus.rd_rdy    = !fifoEmpty;
    assign bus.frame_err = frameErr_q;
    assign bus.overrun   = overrun_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
//   Directed bench for uart_rx_fifo: drives 8N1 frames on rx at 16 clocks
//   per bit from a behavioural driver and pops bytes through the interface.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int BAUD = 16;

    logic clk;
    logic rst_n;
    logic rx;

    int testsRun    = 0;
    int testsFailed = 0;
    int feCnt       = 0;
    int ovCnt       = 0;
    int bothCnt     = 0;

    uart_rx_fifo_if #(.DATA_BITS(8)) bus ();

    uart_rx_fifo #(
        .BAUD_DIV   (BAUD),
        .DATA_BITS  (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx_i  (rx),
        .bus   (bus)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count error strobe cycles, sampled on the falling edge
    always @(negedge clk) begin
        if (bus.frame_err) feCnt++;
        if (bus.overrun) ovCnt++;
        if (bus.frame_err && bus.overrun) bothCnt++;
    end

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Hold rx at a level for n bit times
    task automatic driveBits(input logic level, input int n);
        rx = level;
        repeat (n * BAUD) @(negedge clk);
    endtask

    // Full 8N1 frame, starting and ending on a falling clock edge
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
        driveBits(1'b0, 1);
        for (int i = 0; i < 8; i++) driveBits(data[i], 1);
        driveBits(stopBit, 1);
    endtask

    // Pop the head byte and check what the buffer looks like afterwards
    task automatic popExpect(input string tag, input logic [7:0] exp, input logic rdyAfter);
        checkOutput($sformatf("%s rdy", tag), 32'(bus.rd_rdy), 32'd1);
        checkOutput($sformatf("%s dout", tag), 32'(bus.dout), 32'(exp));
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        checkOutput($sformatf("%s rdy after pop", tag), 32'(bus.rd_rdy), 32'(rdyAfter));
    endtask

    initial begin
        rst_n     = 1'b0;
        rx        = 1'b1;
        bus.rd_en = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        checkOutput("reset rd_rdy", 32'(bus.rd_rdy), 32'd0);
        checkOutput("reset dout", 32'(bus.dout), 32'd0);
        checkOutput("reset frame_err", 32'(bus.frame_err), 32'd0);
        checkOutput("reset overrun", 32'(bus.overrun), 32'd0);
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // 1: single frame 0xE8, exact rd_rdy latency after mid stop bit
        driveBits(1'b0, 1);
        for (int i = 0; i < 8; i++) driveBits(1'((8'hE8 >> i) & 8'h01), 1);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("t1 rdy before stop sample", 32'(bus.rd_rdy), 32'd0);
        checkOutput("t1 busy before stop sample", 32'(bus.busy), 32'd1);
        @(negedge clk);
        checkOutput("t1 rdy after stop sample", 32'(bus.rd_rdy), 32'd1);
        checkOutput("t1 busy after stop sample", 32'(bus.busy), 32'd0);
        popExpect("t1", 8'hE8, 1'b0);
        repeat (4) @(negedge clk);

        // 2: four frames back-to-back fill the buffer
        applyStimulus(8'hCA, 1'b1);
        applyStimulus(8'h4B, 1'b1);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'hFF, 1'b1);
        checkOutput("t2 rdy full", 32'(bus.rd_rdy), 32'd1);
        checkOutput("t2 overrun count", 32'(ovCnt), 32'd0);

        // 3: fifth frame with buffer full is dropped
        applyStimulus(8'h55, 1'b1);
        checkOutput("t3 overrun count", 32'(ovCnt), 32'd1);
        checkOutput("t3 frame_err count", 32'(feCnt), 32'd0);
        popExpect("t3 pop1", 8'hCA, 1'b1);
        popExpect("t3 pop2", 8'h4B, 1'b1);
        popExpect("t3 pop3", 8'h00, 1'b1);
        popExpect("t3 pop4", 8'hFF, 1'b0);

        // 4: bad stop bit, then a good frame after one idle bit
        applyStimulus(8'h3C, 1'b0);
        checkOutput("t4 frame_err count", 32'(feCnt), 32'd1);
        checkOutput("t4 rdy after bad frame", 32'(bus.rd_rdy), 32'd0);
        driveBits(1'b1, 1);
        applyStimulus(8'h96, 1'b1);
        popExpect("t4", 8'h96, 1'b0);

        // 5: short low glitch is rejected by the start-bit check
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        checkOutput("t5 busy during glitch", 32'(bus.busy), 32'd1);
        repeat (30) @(negedge clk);
        checkOutput("t5 busy after glitch", 32'(bus.busy), 32'd0);
        checkOutput("t5 rdy after glitch", 32'(bus.rd_rdy), 32'd0);
        checkOutput("t5 frame_err count", 32'(feCnt), 32'd1);

        // 6: reset in the middle of 0xA5 drops the partial byte
        driveBits(1'b0, 1);
        driveBits(1'b1, 1);
        driveBits(1'b0, 1);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("t6 busy after reset", 32'(bus.busy), 32'd0);
        checkOutput("t6 rdy after reset", 32'(bus.rd_rdy), 32'd0);
        checkOutput("t6 dout after reset", 32'(bus.dout), 32'd0);
        repeat (20) @(negedge clk);
        applyStimulus(8'h5A, 1'b1);
        popExpect("t6", 8'h5A, 1'b0);

        // Break: line held low gives exactly one framing error
        rx = 1'b0;
        repeat (400) @(negedge clk);
        checkOutput("break busy while low", 32'(bus.busy), 32'd0);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("break frame_err count", 32'(feCnt), 32'd2);
        checkOutput("break rdy", 32'(bus.rd_rdy), 32'd0);
        checkOutput("overrun total", 32'(ovCnt), 32'd1);
        checkOutput("error strobes coincident", 32'(bothCnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
